// File: rtl/hex2ascii_stream.sv
// Streams the hexadecimal ASCII text of a captured binary value, one character
// per output handshake, with optional "0x" prefix, leading-zero suppression and CR/LF.
module hex2ascii_stream #(
  parameter int NBYTES    = 2,
  parameter bit UPPERCASE = 1'b1,
  parameter bit NEWLINE   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NBYTES*8-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_prefix,
  input  logic                in_lzs,
  output logic [7:0]          out_char,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int W  = NBYTES * 8;
  localparam int ND = NBYTES * 2;
  localparam int IW = $clog2(ND);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFIX0,
    S_PREFIX1,
    S_DIGIT,
    S_CR,
    S_LF
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      out_char_q, out_char_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    data_q, data_d;
  logic [IW-1:0]   idx_q, idx_d;

  function automatic logic [3:0] nibble_at(input logic [W-1:0] d, input logic [IW-1:0] i);
    return d[{i, 2'b00} +: 4];
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) c = 8'h30 + {4'h0, n};
    else           c = (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    return c;
  endfunction

  // Index of the first digit to emit: the top nibble, or with suppression the
  // highest non-zero nibble (0 for a zero value, so a single '0' is printed).
  function automatic logic [IW-1:0] first_idx(input logic [W-1:0] d, input logic lzs);
    logic [IW-1:0] idx;
    idx = IW'(ND - 1);
    if (lzs) begin
      idx = '0;
      for (int i = 0; i < ND; i++) begin
        if (nibble_at(d, IW'(i)) != 4'h0) idx = IW'(i);
      end
    end
    return idx;
  endfunction

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    out_char_d  = out_char_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    idx_d       = idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d      = in_data;
          idx_d       = first_idx(in_data, in_lzs);
          out_valid_d = 1'b1;
          if (in_prefix) begin
            state_d    = S_PREFIX0;
            out_char_d = 8'h30;
          end else begin
            state_d    = S_DIGIT;
            out_char_d = hex_char(nibble_at(in_data, first_idx(in_data, in_lzs)));
          end
        end
      end
      S_PREFIX0: begin
        if (out_ready) begin
          state_d    = S_PREFIX1;
          out_char_d = 8'h78;
        end
      end
      S_PREFIX1: begin
        if (out_ready) begin
          state_d    = S_DIGIT;
          out_char_d = hex_char(nibble_at(data_q, idx_q));
        end
      end
      S_DIGIT: begin
        if (out_ready) begin
          if (idx_q == '0) begin
            if (NEWLINE) begin
              state_d    = S_CR;
              out_char_d = 8'h0D;
            end else begin
              state_d     = S_IDLE;
              out_char_d  = 8'h00;
              out_valid_d = 1'b0;
            end
          end else begin
            idx_d      = idx_q - IW'(1);
            out_char_d = hex_char(nibble_at(data_q, idx_q - IW'(1)));
          end
        end
      end
      S_CR: begin
        if (out_ready) begin
          state_d    = S_LF;
          out_char_d = 8'h0A;
        end
      end
      S_LF: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_char_d  = 8'h00;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values; the reset clears the small capture registers too, so a
  // stream aborted by reset leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_char_q  <= 8'h00;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_char_q  <= out_char_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
    end
  end

  assign out_char  = out_char_q;
  assign out_valid = out_valid_q;
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_hex2ascii_stream.sv
// Scoreboard bench for hex2ascii_stream: drivers push expected characters,
// monitors pop and compare on every output handshake.
module tb_hex2ascii_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: UPPERCASE=1, NEWLINE=1
  logic [15:0] a_in_data;
  logic        a_in_valid, a_in_prefix, a_in_lzs, a_in_ready;
  logic [7:0]  a_out_char;
  logic        a_out_valid, a_out_ready, a_busy;

  // Instance B: UPPERCASE=0, NEWLINE=0
  logic [15:0] b_in_data;
  logic        b_in_valid, b_in_prefix, b_in_lzs, b_in_ready;
  logic [7:0]  b_out_char;
  logic        b_out_valid, b_out_ready, b_busy;

  hex2ascii_stream #(.NBYTES(2), .UPPERCASE(1'b1), .NEWLINE(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_prefix(a_in_prefix), .in_lzs(a_in_lzs),
    .out_char(a_out_char), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .busy(a_busy)
  );

  hex2ascii_stream #(.NBYTES(2), .UPPERCASE(1'b0), .NEWLINE(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_prefix(b_in_prefix), .in_lzs(b_in_lzs),
    .out_char(b_out_char), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .busy(b_busy)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] a_exp[$];
  logic [7:0] b_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_a(input string s);
    for (int i = 0; i < s.len(); i++) a_exp.push_back(s[i]);
  endtask

  task automatic push_b(input string s);
    for (int i = 0; i < s.len(); i++) b_exp.push_back(s[i]);
  endtask

  // Monitors: every output handshake must match the next expected character.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && a_out_valid && a_out_ready) begin
        if (a_exp.size() == 0) check("a_unexpected_char", {24'h0, a_out_char}, 32'hFFFF_FFFF);
        else begin
          e = a_exp.pop_front();
          check("a_char", {24'h0, a_out_char}, {24'h0, e});
        end
      end
    end
  end

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && b_out_valid && b_out_ready) begin
        if (b_exp.size() == 0) check("b_unexpected_char", {24'h0, b_out_char}, 32'hFFFF_FFFF);
        else begin
          e = b_exp.pop_front();
          check("b_char", {24'h0, b_out_char}, {24'h0, e});
        end
      end
    end
  end

  task automatic send_a(input logic [15:0] d, input logic p, input logic z);
    int n;
    n = 0;
    a_in_data = d; a_in_prefix = p; a_in_lzs = z; a_in_valid = 1'b1;
    @(negedge clk);
    while (!a_in_ready && n < 200) begin @(negedge clk); n++; end
    check("a_accept", {31'h0, a_in_ready}, 32'h1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] d, input logic p, input logic z);
    int n;
    n = 0;
    b_in_data = d; b_in_prefix = p; b_in_lzs = z; b_in_valid = 1'b1;
    @(negedge clk);
    while (!b_in_ready && n < 200) begin @(negedge clk); n++; end
    check("b_accept", {31'h0, b_in_ready}, 32'h1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((a_exp.size() + b_exp.size() != 0 || !a_in_ready || !b_in_ready) && n < 300) begin
      @(negedge clk); n++;
    end
    check(name, a_exp.size() + b_exp.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    a_in_data = '0; a_in_valid = 1'b0; a_in_prefix = 1'b0; a_in_lzs = 1'b0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_valid = 1'b0; b_in_prefix = 1'b0; b_in_lzs = 1'b0; b_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'h0, a_out_valid}, 32'h0);
    check("rst_out_char",  {24'h0, a_out_char},  32'h0);
    check("rst_busy",      {31'h0, a_busy},      32'h0);
    check("rst_in_ready",  {31'h0, a_in_ready},  32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic stream: no gaps, in_ready back on cycle 7
    push_a("1A3F\r\n");
    send_a(16'h1A3F, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("a_no_bubble", {31'h0, a_out_valid}, 32'h1);
    end
    @(negedge clk);
    check("a_done_valid",    {31'h0, a_out_valid}, 32'h0);
    check("a_done_in_ready", {31'h0, a_in_ready},  32'h1);
    check("a_done_busy",     {31'h0, a_busy},      32'h0);
    @(posedge clk); #1;

    // Prefix and leading-zero suppression
    push_a("0xB0\r\n");
    send_a(16'h00B0, 1'b1, 1'b1);
    push_a("0\r\n");
    send_a(16'h0000, 1'b0, 1'b1);
    push_a("0x0005\r\n");
    send_a(16'h0005, 1'b1, 1'b0);
    push_a("F00\r\n");
    send_a(16'h0F00, 1'b0, 1'b1);

    // Lowercase, no newline
    push_b("abcd");
    send_b(16'hABCD, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b_no_bubble", {31'h0, b_out_valid}, 32'h1);
    end
    @(negedge clk);
    check("b_done_valid",    {31'h0, b_out_valid}, 32'h0);
    check("b_done_in_ready", {31'h0, b_in_ready},  32'h1);
    @(posedge clk); #1;
    push_b("0x9f0");
    send_b(16'h09F0, 1'b1, 1'b1);
    push_b("0");
    send_b(16'h0000, 1'b0, 1'b1);
    wait_drain("drain_basic");

    // Backpressure: 'A' held for three stalled cycles plus the handshake cycle
    push_a("1A3F\r\n");
    send_a(16'h1A3F, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_char",  {24'h0, a_out_char},  32'h41);
      check("stall_valid", {31'h0, a_out_valid}, 32'h1);
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    wait_drain("drain_stall");

    // in_valid held with a different value while busy is ignored
    push_a("1A3F\r\n");
    push_a("5555\r\n");
    send_a(16'h1A3F, 1'b0, 1'b0);
    a_in_data = 16'h5555; a_in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!a_in_ready && n < 100) begin @(negedge clk); n++; end
    check("hold_first_done", a_exp.size(), 6);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    wait_drain("drain_hold");

    // Mid-stream reset after the second character
    push_a("1A");
    send_a(16'h1A3F, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'h0, a_out_valid}, 32'h0);
    check("abort_in_ready",  {31'h0, a_in_ready},  32'h1);
    check("abort_out_char",  {24'h0, a_out_char},  32'h0);
    check("abort_queue",     a_exp.size(), 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_a("BEEF\r\n");
    send_a(16'hBEEF, 1'b0, 1'b0);
    @(negedge clk);
    check("post_reset_first", {24'h0, a_out_char}, 32'h42);
    wait_drain("drain_final");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hex2ascii_stream.md
HEX2ASCII_STREAM -- requirements
Module: hex2ascii_stream

Interface
REQ-001 Parameter NBYTES, default 2, sets the binary input width to NBYTES*8 bits; legal range 1..8.
REQ-002 Parameter UPPERCASE, default 1; 1 maps hex letters to 'A'-'F', 0 maps them to 'a'-'f'.
REQ-003 Parameter NEWLINE, default 1; 1 appends CR (0x0D) then LF (0x0A) after the last digit, 0 appends nothing.
REQ-004 clk  input  1  single clock; every register updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  NBYTES*8  binary value to convert.
REQ-007 in_valid  input  1  in_data, in_prefix and in_lzs are valid.
REQ-008 in_ready  output  1  block accepts a new value; high only in IDLE.
REQ-009 in_prefix  input  1  emit "0x" (0x30, 0x78) before the digits.
REQ-010 in_lzs  input  1  suppress leading zero digits.
REQ-011 out_char  output  8  ASCII character, registered.
REQ-012 out_valid  output  1  out_char is valid, registered.
REQ-013 out_ready  input  1  downstream accepts out_char.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL have states IDLE, PREFIX0, PREFIX1, DIGIT, CR and LF.
REQ-016 An input handshake (in_valid & in_ready) in IDLE SHALL capture in_data, in_prefix and in_lzs into internal registers; inputs are ignored at all other times.
REQ-017 The first character SHALL appear on out_valid/out_char in the cycle after the input handshake (latency 1).
REQ-018 An output handshake is out_valid & out_ready; while out_valid is high and out_ready is low, out_char and out_valid SHALL hold stable.
REQ-019 Each output handshake SHALL load the next character, or deassert out_valid after the final one, in the next cycle; there are no bubbles while out_ready is high.
REQ-020 The character sequence is:
- "0x", if prefix is set;
- the hex digits, most-significant nibble first;
- CR, LF, if NEWLINE=1.
REQ-021 Digit mapping: nibble n in 0..9 gives 0x30+n; n in 10..15 gives 0x41+(n-10) when UPPERCASE=1, or 0x61+(n-10) when UPPERCASE=0.
REQ-022 With lzs=0 the block SHALL emit exactly NBYTES*2 digits.
REQ-023 With lzs=1 the block SHALL skip leading zero nibbles and emit from the first non-zero nibble.
REQ-024 With lzs=1 and a value of zero, the block SHALL emit a single '0'.
REQ-025 Skipping zero nibbles SHALL add no output cycles; the first emitted digit is the first non-zero nibble, still at latency 1.
REQ-026 A nibble index counter SHALL track the digit position; DIGIT exits after index 0, to CR if NEWLINE=1, else to IDLE.
REQ-027 The FSM SHALL return to IDLE in the cycle after the final output handshake; in_ready goes high in that same cycle.
REQ-028 A new input SHALL be accepted no earlier than one cycle after the final character is accepted.

Reset
REQ-029 While rst_n is low, the block SHALL hold: state IDLE, out_valid 0, out_char 0x00, busy 0, in_ready 1, all captured registers 0.
REQ-030 Reset assertion mid-stream SHALL abort the stream immediately and asynchronously; no further characters from that value are emitted after release.
REQ-031 After rst_n deasserts, the first in_valid sampled on a rising edge SHALL be accepted normally.

Verification
REQ-032 NBYTES=2, UPPERCASE=1, NEWLINE=1, data 0x1A3F, prefix 0, lzs 0, out_ready 1 -> 0x31,0x41,0x33,0x46,0x0D,0x0A on 6 consecutive cycles starting 1 cycle after accept; in_ready high on cycle 7.
REQ-033 Data 0x00B0, prefix 1, lzs 1 -> 0x30,0x78,0x42,0x30,0x0D,0x0A; data 0x0000, lzs 1 -> 0x30,0x0D,0x0A.
REQ-034 UPPERCASE=0, NEWLINE=0, data 0xABCD -> 0x61,0x62,0x63,0x64, then out_valid low and in_ready high.
REQ-035 Data 0x1A3F with out_ready held low 3 cycles while 0x41 is presented -> 0x41 stable for 4 cycles; full sequence intact, no drop or duplicate.
REQ-036 in_valid held high with a different value while busy -> ignored; second value accepted only after LF handshake and in_ready high.
REQ-037 rst_n pulsed low after the second character -> out_valid 0 asynchronously, in_ready 1; a new value after release streams from its first character.
